prescaler: RTL and testbench



---
 rtl/prescaler.sv | 32 +++
 tb/tb_prescaler.sv | 106 ++++++++++
 2 files changed

// File: rtl/prescaler.sv
// rtl/prescaler.sv - divides clk into a registered 50% duty square wave toggling every HALF_PERIOD cycles
module prescaler #(
  parameter int HALF_PERIOD = 50000,
  parameter int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("prescaler: HALF_PERIOD must be at least 1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Terminal count reloads to zero, so cnt never walks past HALF_PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prescaler.sv
// tb/tb_prescaler.sv - randomized-reset scoreboard bench for prescaler across several HALF_PERIOD values
module tb_prescaler;

  localparam int NINST = 5;
  localparam int HPS [NINST] = '{1, 2, 3, 4, 5};
  localparam int NCYC = 1200;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
    localparam int HP = HPS[gi];

    typedef struct {
      logic out;
      int   cnt;
    } exp_t;

    logic rst;
    logic clk_out;
    exp_t q[$];

    prescaler #(.HALF_PERIOD(HP)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .clk_out (clk_out)
    );

    // Reference: n = rising edges since the last reset edge; output phase is n/HP, count is n%HP.
    initial begin : stim
      int n;
      int hold;
      bit mid_done;
      n = 0;
      hold = 0;
      mid_done = 1'b0;
      rst = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
        if (cyc < 3) begin
          rst = 1'b1;
        end else if (hold > 0) begin
          rst = 1'b1;
          hold--;
        end else if (!mid_done && n == HP + HP / 2) begin
          rst = 1'b1;
          mid_done = 1'b1;
        end else if ($urandom_range(0, 59) == 0) begin
          rst = 1'b1;
          hold = $urandom_range(0, 2);
        end else begin
          rst = 1'b0;
        end
        n = rst ? 0 : n + 1;
        q.push_back('{out: (((n / HP) % 2) == 1), cnt: n % HP});
        @(posedge clk);
        @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL hp%0d drain: pending=%0d expected=0", HP, q.size());
      end
      done_cnt++;
    end

    initial begin : mon
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          total++;
          if (clk_out !== e.out) begin
            bad++;
            $display("FAIL hp%0d clk_out t=%0t got=%b expected=%b", HP, $time, clk_out, e.out);
          end
          total++;
          if (int'(u_dut.cnt) != e.cnt) begin
            bad++;
            $display("FAIL hp%0d cnt t=%0t got=%0d expected=%0d", HP, $time, u_dut.cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    repeat (NCYC + 20) @(posedge clk);
    #2;
    total++;
    if (done_cnt != NINST) begin
      bad++;
      $display("FAIL completion: finished=%0d expected=%0d", done_cnt, NINST);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
